// File: rtl/mult_arb.sv
// mult_arb: round-robin sharing of one pipelined multiplier by two requesters.
// Optional MULT_ARB_FLUSH_EN adds a flush port that drops in-flight ops.
module mult_arb #(
  parameter int WIDTH_D = 32,
  parameter int MUL_LAT = 1
) (
  input  logic               clk,
  input  logic               rst_n,
`ifdef MULT_ARB_FLUSH_EN
  input  logic               flush,
`endif
  input  logic               req0_valid,
  output logic               req0_ready,
  input  logic [WIDTH_D-1:0] req0_a,
  input  logic [WIDTH_D-1:0] req0_b,
  input  logic               req1_valid,
  output logic               req1_ready,
  input  logic [WIDTH_D-1:0] req1_a,
  input  logic [WIDTH_D-1:0] req1_b,
  output logic [WIDTH_D-1:0] mul_a,
  output logic [WIDTH_D-1:0] mul_b,
  input  logic [WIDTH_D-1:0] mul_p,
  output logic               rsp0_valid,
  output logic [WIDTH_D-1:0] rsp0_data,
  output logic               rsp1_valid,
  output logic [WIDTH_D-1:0] rsp1_data,
  output logic               busy
);

  logic               fl;
  logic               rr_ptr;
  logic               gnt0;
  logic               gnt1;
  logic               xfer;
  logic [MUL_LAT-1:0] tag_vld;
  logic [MUL_LAT-1:0] tag_id;
  logic               ret_vld;
  logic               ret_id;

`ifdef MULT_ARB_FLUSH_EN
  assign fl = flush;
`else
  assign fl = 1'b0;
`endif

  // Grant: sole requester wins, rr_ptr breaks ties; nothing in reset/flush
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (rst_n && !fl) begin
      gnt0 = req0_valid & (~req1_valid | ~rr_ptr);
      gnt1 = req1_valid & (~req0_valid | rr_ptr);
    end
  end

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;
  assign xfer       = gnt0 | gnt1;

  // Operand mux towards the multiplier, zero when idle
  always_comb begin
    mul_a = '0;
    mul_b = '0;
    unique case (1'b1)
      gnt0: begin
        mul_a = req0_a;
        mul_b = req0_b;
      end
      gnt1: begin
        mul_a = req1_a;
        mul_b = req1_b;
      end
      default: ;
    endcase
  end

  // Pointer flips to the other requester after every transfer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= 1'b0;
    end else if (xfer) begin
      rr_ptr <= ~gnt1;
    end
  end

  // Tag pipe tracks {valid, owner} alongside the multiplier latency
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_vld <= '0;
      tag_id  <= '0;
    end else begin
      tag_vld[0] <= xfer;
      tag_id[0]  <= gnt1;
      for (int i = 1; i < MUL_LAT; i++) begin
        tag_vld[i] <= tag_vld[i-1] & ~fl;
        tag_id[i]  <= tag_id[i-1];
      end
    end
  end

  assign ret_vld = tag_vld[MUL_LAT-1] & ~fl;
  assign ret_id  = tag_id[MUL_LAT-1];

  // Register the returning product into the owner's response slot
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      rsp0_data  <= '0;
      rsp1_data  <= '0;
    end else begin
      rsp0_valid <= ret_vld & ~ret_id;
      rsp1_valid <= ret_vld & ret_id;
      if (ret_vld && !ret_id) rsp0_data <= mul_p;
      if (ret_vld && ret_id)  rsp1_data <= mul_p;
    end
  end

  assign busy = (|tag_vld) | rsp0_valid | rsp1_valid;

endmodule

// File: tb/tb_mult_arb.sv
// tb_mult_arb: directed checks of mult_arb with MUL_LAT=1 (uA) and 2 (uB).
// External multipliers are modelled here as register pipelines.
module tb_mult_arb;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // DUT A signals (MUL_LAT=1)
  logic        v0A, v1A, r0A, r1A, rv0A, rv1A, bsyA;
  logic [31:0] a0A, b0A, a1A, b1A, maA, mbA, pA, d0A, d1A;
  // DUT B signals (MUL_LAT=2)
  logic        v0B, v1B, r0B, r1B, rv0B, rv1B, bsyB;
  logic [31:0] a0B, b0B, a1B, b1B, maB, mbB, pB, pB1, d0B, d1B;
  logic        flB;

  mult_arb #(.WIDTH_D(32), .MUL_LAT(1)) uA (
    .clk(clk), .rst_n(rst_n),
`ifdef MULT_ARB_FLUSH_EN
    .flush(1'b0),
`endif
    .req0_valid(v0A), .req0_ready(r0A), .req0_a(a0A), .req0_b(b0A),
    .req1_valid(v1A), .req1_ready(r1A), .req1_a(a1A), .req1_b(b1A),
    .mul_a(maA), .mul_b(mbA), .mul_p(pA),
    .rsp0_valid(rv0A), .rsp0_data(d0A),
    .rsp1_valid(rv1A), .rsp1_data(d1A), .busy(bsyA)
  );

  mult_arb #(.WIDTH_D(32), .MUL_LAT(2)) uB (
    .clk(clk), .rst_n(rst_n),
`ifdef MULT_ARB_FLUSH_EN
    .flush(flB),
`endif
    .req0_valid(v0B), .req0_ready(r0B), .req0_a(a0B), .req0_b(b0B),
    .req1_valid(v1B), .req1_ready(r1B), .req1_a(a1B), .req1_b(b1B),
    .mul_a(maB), .mul_b(mbB), .mul_p(pB),
    .rsp0_valid(rv0B), .rsp0_data(d0B),
    .rsp1_valid(rv1B), .rsp1_data(d1B), .busy(bsyB)
  );

  always @(posedge clk) begin
    pA  <= maA * mbA;
    pB1 <= maB * mbB;
    pB  <= pB1;
  end

  typedef struct {
    logic        v0;
    logic [31:0] a0, b0;
    logic        v1;
    logic [31:0] a1, b1;
    logic        r0, r1;
    logic [31:0] ma, mb;
    logic        rv0, rv1;
    logic [31:0] d0, d1;
    logic        bsy;
  } vec_t;

  vec_t tbl [10];

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] ff;
    ff = 32'hFFFF_FFFF;
    {v0A, v1A, v0B, v1B, flB} = '0;
    {a0A, b0A, a1A, b1A} = '0;
    {a0B, b0B, a1B, b1B} = '0;

    tbl[0] = '{1, 2, 1, 1, 3, 1, 1, 0, 2, 1, 0, 0, 0, 0, 0};
    tbl[1] = '{1, 2, 2, 1, 3, 2, 0, 1, 3, 2, 0, 0, 0, 0, 1};
    tbl[2] = '{1, 2, 3, 1, 3, 3, 1, 0, 2, 3, 1, 0, 2, 0, 1};
    tbl[3] = '{1, 2, 4, 1, 3, 4, 0, 1, 3, 4, 0, 1, 2, 6, 1};
    tbl[4] = '{1, 7, 6, 0, 0, 0, 1, 0, 7, 6, 1, 0, 6, 6, 1};
    tbl[5] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 6, 12, 1};
    tbl[6] = '{0, 0, 0, 1, ff, ff, 0, 1, ff, ff, 1, 0, 42, 12, 1};
    tbl[7] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 42, 12, 1};
    tbl[8] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 42, 1, 1};
    tbl[9] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 42, 1, 0};

    // reset state
    #2;
    chk("rst_ready0", {31'b0, r0A}, 0);
    chk("rst_busy", {31'b0, bsyA}, 0);
    chk("rst_d0", d0A, 0);
    nxt();
    nxt();
    rst_n = 1'b1;
    nxt();

    // table: contention, single requester, wrap
    for (int i = 0; i < 10; i++) begin
      v0A = tbl[i].v0;
      a0A = tbl[i].a0;
      b0A = tbl[i].b0;
      v1A = tbl[i].v1;
      a1A = tbl[i].a1;
      b1A = tbl[i].b1;
      @(negedge clk);
      chk($sformatf("t%0d_ready0", i), {31'b0, r0A}, {31'b0, tbl[i].r0});
      chk($sformatf("t%0d_ready1", i), {31'b0, r1A}, {31'b0, tbl[i].r1});
      chk($sformatf("t%0d_mul_a", i), maA, tbl[i].ma);
      chk($sformatf("t%0d_mul_b", i), mbA, tbl[i].mb);
      chk($sformatf("t%0d_rsp0_v", i), {31'b0, rv0A}, {31'b0, tbl[i].rv0});
      chk($sformatf("t%0d_rsp1_v", i), {31'b0, rv1A}, {31'b0, tbl[i].rv1});
      chk($sformatf("t%0d_rsp0_d", i), d0A, tbl[i].d0);
      chk($sformatf("t%0d_rsp1_d", i), d1A, tbl[i].d1);
      chk($sformatf("t%0d_busy", i), {31'b0, bsyA}, {31'b0, tbl[i].bsy});
      nxt();
    end

    // reset mid-flight: op (3,5) must never be answered
    v0A = 1; a0A = 3; b0A = 5;
    @(negedge clk);
    chk("rmf_issue", {31'b0, r0A}, 1);
    nxt();
    rst_n = 1'b0;
    v1A = 1; a1A = 1; b1A = 1;
    @(negedge clk);
    chk("rmf_ready0", {31'b0, r0A}, 0);
    chk("rmf_ready1", {31'b0, r1A}, 0);
    chk("rmf_busy", {31'b0, bsyA}, 0);
    nxt();
    v0A = 0; v1A = 0;
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("rmf_rsp0_v%0d", k), {31'b0, rv0A}, 0);
      chk($sformatf("rmf_busy%0d", k), {31'b0, bsyA}, 0);
      nxt();
    end
    v0A = 1; v1A = 1;
    @(negedge clk);
    chk("rmf_rr_g0", {31'b0, r0A}, 1);
    chk("rmf_rr_g1", {31'b0, r1A}, 0);
    nxt();
    v0A = 0; v1A = 0;
    nxt();
    nxt();

    // MUL_LAT=2 back-to-back
    for (int k = 0; k < 7; k++) begin
      v0B = (k < 3);
      a0B = k + 1;
      b0B = k + 1;
      @(negedge clk);
      if (k < 3) chk($sformatf("l2_ready%0d", k), {31'b0, r0B}, 1);
      chk($sformatf("l2_rsp0_v%0d", k), {31'b0, rv0B},
          {31'b0, (k >= 3 && k <= 5)});
      if (k >= 3 && k <= 5)
        chk($sformatf("l2_rsp0_d%0d", k), d0B, (k - 2) * (k - 2));
      chk($sformatf("l2_busy%0d", k), {31'b0, bsyB},
          {31'b0, (k >= 1 && k <= 5)});
      nxt();
    end
    v0B = 0;

`ifdef MULT_ARB_FLUSH_EN
    // flush drops the in-flight op; later op still answered
    for (int k = 0; k < 6; k++) begin
      v0B = (k == 0);
      a0B = 4; b0B = 4;
      flB = (k == 1);
      v1B = (k == 1 || k == 2);
      a1B = 5; b1B = 5;
      @(negedge clk);
      if (k == 0) chk("fl_issue0", {31'b0, r0B}, 1);
      if (k == 1) chk("fl_ready1", {31'b0, r1B}, 0);
      if (k == 2) chk("fl_issue1", {31'b0, r1B}, 1);
      chk($sformatf("fl_rsp0_v%0d", k), {31'b0, rv0B}, 0);
      chk($sformatf("fl_rsp1_v%0d", k), {31'b0, rv1B},
          {31'b0, (k == 5)});
      if (k == 5) chk("fl_rsp1_d", d1B, 25);
      nxt();
    end
    {v0B, v1B, flB} = '0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
